// File: rtl/config_mem_sequencer.sv
// Purpose : streams a byte range from a byte-wide memory and packs it into little-endian
//           configuration words; shares the memory with a host byte-write port.
// Latency : 2 cycles per byte plus at least 1 PUSH cycle per word; start to first cfg_valid
//           is 2*CFG_WIDTH/8+1 cycles.
// Backpressure: cfg_valid and cfg_data hold until cfg_ready is sampled high. Host writes are
//           stalled with host_waitrequest while a load runs or while start is asserted.
// Ports   : clk/reset (sync, active high); start/base_addr/byte_count start a load, with
//           busy/done/err as status; host_* is the host write port into the memory; mem_* is
//           the memory master port, with read data one cycle after the address; cfg_* is the
//           word output stream, with cfg_last marking the final word.
module config_mem_sequencer #(
    parameter int CFG_WIDTH = 32,
    parameter int MEM_DEPTH = 100000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [16:0]          base_addr,
    input  logic [16:0]          byte_count,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    input  logic [16:0]          host_address,
    input  logic                 host_write,
    input  logic [7:0]           host_writedata,
    output logic                 host_waitrequest,
    output logic [16:0]          mem_address,
    output logic                 mem_chipselect,
    output logic                 mem_write,
    output logic [7:0]           mem_writedata,
    output logic                 mem_clken,
    input  logic [7:0]           mem_readdata,
    output logic [CFG_WIDTH-1:0] cfg_data,
    output logic                 cfg_valid,
    input  logic                 cfg_ready,
    output logic                 cfg_last
);

    localparam int          BPW     = CFG_WIDTH / 8;
    localparam int          IDXW    = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [16:0] BPW17   = 17'(BPW);
    localparam logic [17:0] DEPTH18 = 18'(MEM_DEPTH);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(BPW - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPTURE,
        PUSH,
        FINISH
    } state_t;

    state_t            state;
    logic [16:0]       addr;
    logic [16:0]       remaining;
    logic [IDXW-1:0]   byte_idx;

    // Range check is done one bit wider so base+count cannot wrap before the compare.
    logic [17:0] end_addr;
    logic        count_bad;
    logic        range_bad;
    logic        reject;

    assign end_addr  = {1'b0, base_addr} + {1'b0, byte_count};
    assign count_bad = (byte_count == 17'd0) || ((byte_count % BPW17) != 17'd0);
    assign range_bad = end_addr > DEPTH18;
    assign reject    = count_bad || range_bad;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            byte_idx  <= '0;
            cfg_data  <= '0;
            cfg_valid <= 1'b0;
            cfg_last  <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (reject) begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= FINISH;
                        end else begin
                            err       <= 1'b0;
                            addr      <= base_addr;
                            remaining <= byte_count;
                            byte_idx  <= '0;
                            state     <= READ;
                        end
                    end
                end

                READ: begin
                    state <= CAPTURE;
                end

                CAPTURE: begin
                    // First byte of a word lands in bits [7:0].
                    cfg_data[int'(byte_idx)*8 +: 8] <= mem_readdata;
                    addr      <= addr + 17'd1;
                    remaining <= remaining - 17'd1;
                    if (byte_idx == LAST_IDX) begin
                        byte_idx  <= '0;
                        cfg_valid <= 1'b1;
                        // remaining still holds the pre-decrement value here.
                        cfg_last  <= (remaining == 17'd1);
                        state     <= PUSH;
                    end else begin
                        byte_idx <= byte_idx + IDXW'(1);
                        state    <= READ;
                    end
                end

                PUSH: begin
                    if (cfg_ready) begin
                        cfg_valid <= 1'b0;
                        cfg_last  <= 1'b0;
                        if (remaining != 17'd0) begin
                            state <= READ;
                        end else begin
                            done  <= 1'b1;
                            state <= FINISH;
                        end
                    end
                end

                FINISH: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The memory port is combinational so a host write lands in the cycle it is accepted.
    // Reset gates every access so an aborted load issues nothing in the reset cycle.
    logic rd_active;
    logic host_accept;

    assign busy             = ~reset & (state != IDLE);
    assign host_waitrequest = ~reset & ((state != IDLE) | start);
    assign host_accept      = ~reset & host_write & ~host_waitrequest;
    assign rd_active        = ~reset & (state == READ);

    always_comb begin
        mem_address    = '0;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_writedata  = '0;
        if (rd_active) begin
            mem_address    = addr;
            mem_chipselect = 1'b1;
        end else if (host_accept) begin
            mem_address    = host_address;
            mem_chipselect = 1'b1;
            mem_write      = 1'b1;
            mem_writedata  = host_writedata;
        end
    end

    assign mem_clken = 1'b1;

endmodule

// File: doc/config_mem_sequencer.md
CONFIG_MEM_SEQUENCER -- requirements
Module: config_mem_sequencer

Interface
REQ-001 Parameter CFG_WIDTH, default 32; configuration word width in bits; SHALL be a multiple of 8, range 8..64.
REQ-002 Parameter MEM_DEPTH, default 100000; number of addressable bytes in the attached memory.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a load; sampled only in IDLE.
REQ-006 base_addr  input  17  first byte address of the load; sampled with start.
REQ-007 byte_count  input  17  number of bytes to load; sampled with start.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse at the end of every load, including error terminations.
REQ-010 err  output  1  error status of the last load; held until the next accepted start.
REQ-011 host_address  input  17  host byte-write address.
REQ-012 host_write  input  1  host write request.
REQ-013 host_writedata  input  8  host write byte.
REQ-014 host_waitrequest  output  1  high while a host write cannot be accepted.
REQ-015 mem_address  output  17  memory address.
REQ-016 mem_chipselect  output  1  memory select.
REQ-017 mem_write  output  1  memory write enable.
REQ-018 mem_writedata  output  8  memory write byte.
REQ-019 mem_clken  output  1  memory clock enable; tied to 1.
REQ-020 mem_readdata  input  8  memory read byte; valid one clk after the address is presented.
REQ-021 cfg_data  output  CFG_WIDTH  assembled configuration word.
REQ-022 cfg_valid  output  1  cfg_data is valid.
REQ-023 cfg_ready  input  1  downstream accepts the word.
REQ-024 cfg_last  output  1  marks the final word of a load; qualified by cfg_valid.

Function
REQ-025 The FSM SHALL have the states IDLE, READ, CAPTURE, PUSH and FINISH.
REQ-026 IDLE + start: a load SHALL be rejected when byte_count==0, when byte_count is not a multiple of CFG_WIDTH/8, or when base_addr+byte_count>MEM_DEPTH (17-bit-safe compare); a rejected load SHALL set err=1 and go to FINISH, and an accepted load SHALL set err=0, latch the address and count, and go to READ.
REQ-027 READ: the block SHALL drive mem_address=current address, mem_chipselect=1 and mem_write=0 for one cycle, then go to CAPTURE.
REQ-028 CAPTURE: the block SHALL shift mem_readdata into the word register little-endian (first byte in bits [7:0]), then increment the address and decrement the remaining count.
REQ-029 After CAPTURE: when the word holds CFG_WIDTH/8 bytes, the next state SHALL be PUSH; otherwise it SHALL be READ.
REQ-030 PUSH: cfg_valid SHALL be 1, cfg_data SHALL be stable, and cfg_last SHALL be 1 when the remaining count==0.
REQ-031 On cfg_ready in PUSH, the next state SHALL be READ when bytes remain, else FINISH.
REQ-032 cfg_valid SHALL NOT drop, and cfg_data SHALL NOT change, until cfg_ready is sampled high.
REQ-033 FINISH: done=1 for exactly one cycle, then the next state SHALL be IDLE.
REQ-034 Throughput SHALL be 2 cycles per byte, plus at least 1 cycle per word in PUSH; start-to-first cfg_valid latency SHALL be 2*CFG_WIDTH/8+1 cycles.
REQ-035 Host port: host_waitrequest SHALL equal (state!=IDLE) | start.
REQ-036 A host write SHALL be accepted when host_write & !host_waitrequest, driving mem_address=host_address, mem_chipselect=1, mem_write=1 and mem_writedata=host_writedata in that same cycle.
REQ-037 When start and host_write coincide in IDLE, start SHALL win and the host write SHALL stall.
REQ-038 When neither a load nor a host write is active, mem_chipselect and mem_write SHALL be 0.
REQ-039 start while busy SHALL be ignored.
REQ-040 Address arithmetic SHALL be 17-bit; no wrap SHALL occur for accepted loads (guaranteed by REQ-026).

Reset
REQ-041 On reset, the block SHALL force state=IDLE, busy=0, done=0, err=0, cfg_valid=0, cfg_last=0, cfg_data=0, mem_chipselect=0, mem_write=0 and host_waitrequest=0.
REQ-042 Reset asserted mid-load SHALL abort the load within one cycle, with no done pulse and no further memory access.

Verification
REQ-043 Preload bytes 0x11,0x22,0x33,0x44,0x55,0x66,0x77,0x88 at address 0x100; start with base 0x100, count 8, cfg_ready=1 -> words 0x44332211 then 0x88776655 (last=1), done 1 cycle after the second handshake, err=0.
REQ-044 Same load with cfg_ready held low 5 cycles in the first PUSH -> cfg_data/cfg_valid stable throughout, no extra memory reads.
REQ-045 start with count 6; then count 0; then base 99998 with count 4 -> each gives err=1 and done pulse, no cfg_valid, no mem_chipselect.
REQ-046 host_write to 0x00005 with 0xA5 during a load -> waitrequest=1 until done; write lands afterward; a read-back load returns 0xA5 in the correct byte lane.
REQ-047 Simultaneous start and host_write in IDLE -> load proceeds, host stalls; then reset asserted after 3 CAPTUREs -> IDLE next cycle, no done, cfg_valid=0.
